// File: rtl/blip_conditioner.sv
// Hall/commutation blip front-end: two-flop synchroniser, qualification filter,
// rising-edge strobe, edge-to-edge period measurement and stall detection.
// Optional glitch counter is built only when BLIP_GLITCH_CNT_EN is defined.
module blip_conditioner #(
   parameter int FILTER_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 50000000,
   parameter int PERIOD_W       = 32
) (
   input  logic                clk50M,
   input  logic                rst_n,
   input  logic                blips_raw,
   output logic                blips,
   output logic                blip_pulse,
   output logic [PERIOD_W-1:0] period,
   output logic                period_valid,
   output logic                stalled,
   output logic [15:0]         glitch_count
);

   // state    | meaning
   // ST_STALL | no usable reference edge; next clean edge only arms
   // ST_RUN   | armed; next clean edge publishes a period
   localparam logic [0:0] ST_STALL = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   localparam int                 QW     = (FILTER_CYCLES > 2) ? $clog2(FILTER_CYCLES) : 1;
   localparam logic [QW-1:0]       Q_LAST = QW'(FILTER_CYCLES - 1);
   localparam logic [PERIOD_W-1:0] PC_MAX = PERIOD_W'(TIMEOUT_CYCLES);
   localparam logic [PERIOD_W-1:0] PC_PRE = PERIOD_W'(TIMEOUT_CYCLES - 1);

   logic          s1;
   logic          s2;
   logic [QW-1:0] q;
   logic          differ;
   logic          q_done;
   logic          rise_accept;

   logic [PERIOD_W-1:0] pc;
   logic [0:0]          state;

   always_ff @(posedge clk50M or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= blips_raw;
         s2 <= s1;
      end
   end

   assign differ      = s2 ^ blips;
   assign q_done      = (q == Q_LAST);
   assign rise_accept = differ & q_done & s2;

   always_ff @(posedge clk50M or negedge rst_n) begin
      if (!rst_n) begin
         blips      <= 1'b0;
         blip_pulse <= 1'b0;
         q          <= '0;
      end else begin
         blip_pulse <= rise_accept;
         if (!differ) begin
            q <= '0;
         end else if (q_done) begin
            blips <= s2;
            q     <= '0;
         end else begin
            q <= q + QW'(1);
         end
      end
   end

`ifdef BLIP_GLITCH_CNT_EN
   // a pulse that dies before qualification completes leaves q non-zero
   logic glitch;
   assign glitch = ~differ & (q != '0);

   always_ff @(posedge clk50M or negedge rst_n) begin
      if (!rst_n) begin
         glitch_count <= 16'd0;
      end else if (glitch && (glitch_count != 16'hFFFF)) begin
         glitch_count <= glitch_count + 16'd1;
      end
   end
`else
   assign glitch_count = 16'd0;
`endif

   // stall is taken on the step into PC_MAX so a spacing of exactly the
   // timeout already sees the disarmed state on the pulse cycle
   always_ff @(posedge clk50M or negedge rst_n) begin
      if (!rst_n) begin
         pc           <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         state        <= ST_STALL;
      end else begin
         period_valid <= 1'b0;
         if (blip_pulse) begin
            pc <= PERIOD_W'(1);
            if (state == ST_RUN) begin
               period       <= pc;
               period_valid <= 1'b1;
            end else begin
               state <= ST_RUN;
            end
         end else if (pc != PC_MAX) begin
            pc <= pc + PERIOD_W'(1);
            if (pc == PC_PRE) begin
               state <= ST_STALL;
            end
         end
      end
   end

   assign stalled = (state == ST_STALL);

endmodule
